// File: rtl/div_if.sv
// div_if: handshake and result bundle between the execute stage and the iterative divider.
interface div_if #(parameter int WIDTH = 32);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
    modport master (output start, is_signed, a, b, cancel, input busy, done, hi, lo, dz);
    modport slave  (input start, is_signed, a, b, cancel, output busy, done, hi, lo, dz);
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for DIV/DIVU, quotient to lo and remainder to hi.
module div_seq #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst,
    div_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] a_r, dv, rem, quo, hi_r, lo_r, qfix, rfix;
    logic [CW-1:0] cnt;
    logic sgn, qs, rs, dz_r;
    logic [WIDTH:0] sh, diff;
    assign sh = {rem, quo[WIDTH-1]};
    assign diff = sh - {1'b0, dv};
    assign qfix = qs ? -quo : quo;
    assign rfix = rs ? -rem : rem;
    assign io.busy = state != IDLE;
    assign io.done = state == DONE;
    assign io.hi = hi_r;
    assign io.lo = lo_r;
    assign io.dz = dz_r;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: nxt = (io.start && !io.cancel) ? PREP : IDLE;
            PREP: nxt = io.cancel ? IDLE : (dv == '0 ? DONE : RUN);
            RUN:  nxt = io.cancel ? IDLE : (cnt == CW'(WIDTH - 1) ? FIX : RUN);
            FIX:  nxt = io.cancel ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            dv <= '0;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            sgn <= 1'b0;
            qs <= 1'b0;
            rs <= 1'b0;
            hi_r <= '0;
            lo_r <= '0;
            dz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (nxt == PREP) begin
                    a_r <= io.a;
                    dv <= io.b;
                    sgn <= io.is_signed;
                end
                PREP: begin
                    quo <= (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
                    dv <= (sgn && dv[WIDTH-1]) ? -dv : dv;
                    rem <= '0;
                    cnt <= '0;
                    qs <= sgn && (a_r[WIDTH-1] ^ dv[WIDTH-1]);
                    rs <= sgn && a_r[WIDTH-1];
                    if (nxt == DONE) begin
                        lo_r <= '1;
                        hi_r <= a_r;
                        dz_r <= 1'b1;
                    end
                end
                RUN: begin
                    rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: if (nxt == DONE) begin
                    lo_r <= qfix;
                    hi_r <= rfix;
                    dz_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with hand-computed quotients, remainders and latencies.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    div_if #(32) io();
    div_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] el, input logic [31:0] eh, input logic ed, input int lat);
        int n;
        int idle;
        @(negedge clk);
        io.start = 1'b1;
        io.is_signed = s;
        io.a = x;
        io.b = y;
        @(negedge clk);
        io.start = 1'b0;
        n = 1;
        idle = 0;
        while (!io.done && n < 60) begin
            if (!io.busy) idle++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".idle"}, idle, 0);
        chk({tag, ".lo"}, io.lo, el);
        chk({tag, ".hi"}, io.hi, eh);
        chk({tag, ".dz"}, io.dz, ed);
        @(negedge clk);
        chk({tag, ".busy_after"}, io.busy, 0);
        chk({tag, ".done_after"}, io.done, 0);
    endtask
    initial begin
        int n;
        int pulses;
        int at;
        io.start = 1'b0;
        io.is_signed = 1'b0;
        io.a = '0;
        io.b = '0;
        io.cancel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.busy", io.busy, 0);
        chk("rst.done", io.done, 0);
        chk("rst.hi", io.hi, 0);
        chk("rst.lo", io.lo, 0);
        chk("rst.dz", io.dz, 0);
        run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        run("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35);
        run("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 35);
        run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 35);
        run("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 35);
        run("dz5", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 2);
        run("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 35);
        run("sdz_m5", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 2);
        run("u1000_33", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 35);
        // cancel mid-run: results from the prior 100/7 must survive
        run("pre_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'd50;
        io.b = 32'd5;
        n = 0;
        pulses = 0;
        at = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            io.start = (n == 12);
            io.cancel = (n == 10);
            if (n == 11) chk("cancel.busy", io.busy, 0);
            if (n == 11) chk("cancel.lo", io.lo, 14);
            if (n == 11) chk("cancel.hi", io.hi, 2);
            if (io.done) begin
                pulses++;
                at = n;
            end
        end
        chk("cancel.pulses", pulses, 1);
        chk("cancel.done_at", at, 47);
        chk("cancel.lo_new", io.lo, 10);
        chk("cancel.hi_new", io.hi, 0);
        // start held through the whole op must not retrigger
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'd100;
        io.b = 32'd7;
        n = 0;
        pulses = 0;
        at = 0;
        while (n < 45) begin
            @(negedge clk);
            n++;
            if (n == 36) io.start = 1'b0;
            if (io.done) begin
                pulses++;
                at = n;
            end
        end
        chk("hold.pulses", pulses, 1);
        chk("hold.done_at", at, 35);
        chk("hold.lo", io.lo, 14);
        @(negedge clk);
        io.start = 1'b1;
        io.a = 32'd77;
        io.b = 32'd4;
        n = 0;
        pulses = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            io.start = 1'b0;
            rst = (n == 20);
            if (n == 21) begin
                chk("rst_mid.busy", io.busy, 0);
                chk("rst_mid.hi", io.hi, 0);
                chk("rst_mid.lo", io.lo, 0);
                chk("rst_mid.dz", io.dz, 0);
            end
            if (io.done) pulses++;
        end
        chk("rst_mid.pulses", pulses, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
